oam_scheduler: RTL and testbench

Per-scanline sprite scheduler for the tank renderer. Holds the object attribute table (OAM) written by game logic, commits it atomically at vblank, and during each horizontal blank selects up to N_SLOT objects that overlap the next line. The selected objects drive the packed `oam_data` words of N_SLOT parallel `tank_engine` instances.

---
 rtl/tank_pkg.sv | 51 +++++
 rtl/oam_table.sv | 36 +++
 rtl/oam_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_oam_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared definitions for the tank renderer sprite path.
//
// Purpose: OAM word field positions, the packed OAM word layout used by both
// the scheduler and the tank_engine instances, and the scheduler state type.
//
// Contents:
//   OBJ_W              width of one OAM word
//   OBJ_* / SPRITE_*   bit positions of each field inside an OAM word
//   oam_word_t         packed view of an OAM word
//   oam_sched_state_t  scheduler FSM states (IDLE / EVAL / COPY)
package tank_pkg;

  localparam int OBJ_W = 32;

  localparam int OBJ_TYPE_MSB   = 30;
  localparam int OBJ_TYPE_LSB   = 29;
  localparam int OBJ_ENABLE     = 28;
  localparam int OBJ_POS_X_MSB  = 27;
  localparam int OBJ_POS_X_LSB  = 18;
  localparam int OBJ_POS_Y_MSB  = 17;
  localparam int OBJ_POS_Y_LSB  = 8;
  localparam int SPRITE_ROW_MSB = 5;
  localparam int SPRITE_ROW_LSB = 3;
  localparam int SPRITE_COL_MSB = 2;
  localparam int SPRITE_COL_LSB = 0;

  // Bit 31 and bits 7:6 are reserved and carried through untouched.
  typedef struct packed {
    logic       rsvd_31;
    logic [1:0] obj_type;
    logic       enable;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] rsvd_7_6;
    logic [2:0] row;
    logic [2:0] col;
  } oam_word_t;

  // Fixed encodings kept as plain constants so older code that compares raw
  // state bits keeps working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EVAL = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EVAL = ST_EVAL,
    COPY = ST_COPY
  } oam_sched_state_t;

endpackage

// File: rtl/oam_table.sv
// N_OBJ x 32 OAM register file.
//
// Purpose: storage for one copy of the object attribute table.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears every entry)
//   we          write enable
//   waddr/wdata synchronous write port
//   raddr/rdata combinational read port
module oam_table
  import tank_pkg::*;
#(
  parameter int N_OBJ = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(N_OBJ)-1:0] waddr,
  input  logic [OBJ_W-1:0]         wdata,
  input  logic [$clog2(N_OBJ)-1:0] raddr,
  output logic [OBJ_W-1:0]         rdata
);

  logic [OBJ_W-1:0] mem [N_OBJ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OBJ; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/oam_scheduler.sv
// Per-scanline sprite scheduler for the tank renderer.
//
// Purpose: game logic writes a shadow OAM table; a commit publishes it into
// the live table during the first vblank line. In each horizontal blank the
// live table is scanned and up to N_SLOT objects overlapping the next line
// are latched, then presented on slot_data for the whole of that line.
//
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   x, y            current raster position
//   wr_valid/ready  write handshake into the shadow table
//   wr_addr/data    shadow entry index and OAM word
//   commit          request publication of the shadow table at next vblank
//   slot_data       N_SLOT packed OAM words, slot k at [32k+31:32k]
//   line_overflow   more than N_SLOT objects hit the current line
//   busy            evaluation or copy in progress
//
// Build option: define OAM_SCHED_PRIO_ROTATE_EN to rotate the scan start
// index once per frame, so overflowed objects flicker instead of vanishing.
module oam_scheduler
  import tank_pkg::*;
#(
  parameter int N_OBJ    = 16,
  parameter int N_SLOT   = 4,
  parameter int SPR_H    = 32,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(N_OBJ)-1:0] wr_addr,
  input  logic [OBJ_W-1:0]         wr_data,
  input  logic                     commit,
  output logic [N_SLOT*OBJ_W-1:0]  slot_data,
  output logic                     line_overflow,
  output logic                     busy
);

  localparam int AW = $clog2(N_OBJ);
  localparam int CW = $clog2(N_SLOT + 1);

  localparam logic [9:0]    X_EVAL   = 10'(H_ACTIVE);
  localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_VBLANK = 10'(V_ACTIVE);
  localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]   Y_ACT11  = 11'(V_ACTIVE);
  localparam logic [10:0]   SPR_H11  = 11'(SPR_H);
  localparam logic [AW-1:0] IDX_LAST = AW'(N_OBJ - 1);
  localparam logic [CW-1:0] SLOTS    = CW'(N_SLOT);

  oam_sched_state_t state;

  logic [AW-1:0]    idx;
  logic [AW-1:0]    scan_addr;
  logic [10:0]      eval_y;
  logic [10:0]      next_y;
  logic [10:0]      obj_top;
  logic             rdy_q;
  logic             commit_pending;
  logic             frame_start;
  logic             line_end;
  logic             eval_go;
  logic             copy_go;
  logic             shadow_we;
  logic             hit;
  logic [OBJ_W-1:0] shadow_rd;
  oam_word_t        live_rd;

  logic [N_SLOT-1:0][OBJ_W-1:0] pend;
  logic [N_SLOT-1:0][OBJ_W-1:0] slot_q;
  logic [CW-1:0]                pend_cnt;
  logic                         pend_ovf;
  logic                         ovf_q;

  assign frame_start = (x == 10'd0) && (y == Y_VBLANK);
  assign line_end    = (x == X_LAST);
  assign next_y      = (y == Y_LAST) ? 11'd0 : {1'b0, y} + 11'd1;
  assign copy_go     = (state == IDLE) && frame_start && commit_pending;
  assign eval_go     = (state == IDLE) && (x == X_EVAL) && (next_y < Y_ACT11);

  assign wr_ready  = rdy_q && (state != COPY);
  assign shadow_we = wr_valid && wr_ready;
  assign busy      = (state == EVAL) || (state == COPY);

  // The shadow table is only ever read by the copy, so its read port follows
  // the copy index; the live table is only written by the copy.
  oam_table #(.N_OBJ(N_OBJ)) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (shadow_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx),
    .rdata (shadow_rd)
  );

  oam_table #(.N_OBJ(N_OBJ)) u_live (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (state == COPY),
    .waddr (idx),
    .wdata (shadow_rd),
    .raddr (scan_addr),
    .rdata (live_rd)
  );

`ifdef OAM_SCHED_PRIO_ROTATE_EN
  // Scan start advances once per frame; N_OBJ is a power of two so the
  // address add wraps naturally.
  logic [AW-1:0] start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= '0;
    end else if (frame_start) begin
      start <= start + AW'(1);
    end
  end

  assign scan_addr = start + idx;
`else
  assign scan_addr = idx;
`endif

  // 11-bit compare so an object near the bottom of the 10-bit range does
  // not wrap around and appear at the top of the screen.
  assign obj_top = {1'b0, live_rd.pos_y};
  assign hit     = live_rd.enable && (eval_y >= obj_top) && (eval_y < obj_top + SPR_H11);

  // Sequencer: IDLE waits for the vblank copy slot or the hblank evaluation
  // slot; both EVAL and COPY walk idx through every entry once. rdy_q makes
  // the write port come up one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      eval_y         <= '0;
      rdy_q          <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        IDLE: begin
          if (copy_go) begin
            state <= COPY;
            idx   <= '0;
          end else if (eval_go) begin
            state  <= EVAL;
            idx    <= '0;
            eval_y <= next_y;
          end
        end
        EVAL, COPY: begin
          idx <= idx + AW'(1);
          if (idx == IDX_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A commit arriving on the cycle the copy starts is covered by that copy.
      if (copy_go) begin
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Hits collect into pending slots in scan order; the last pixel of the
  // line publishes them and clears pending for the next evaluation, so
  // lines that were never evaluated show empty slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
      pend_ovf <= 1'b0;
      slot_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (line_end) begin
      slot_q   <= pend;
      ovf_q    <= pend_ovf;
      pend     <= '0;
      pend_cnt <= '0;
      pend_ovf <= 1'b0;
    end else if ((state == EVAL) && hit) begin
      if (pend_cnt < SLOTS) begin
        for (int k = 0; k < N_SLOT; k++) begin
          if (pend_cnt == CW'(k)) pend[k] <= live_rd;
        end
        pend_cnt <= pend_cnt + CW'(1);
      end else begin
        pend_ovf <= 1'b1;
      end
    end
  end

  assign slot_data     = slot_q;
  assign line_overflow = ovf_q;

endmodule

// File: tb/tb_oam_scheduler.sv
// Self-checking bench for oam_scheduler with a shrunken raster so several
// frames fit in a short run. Expected per-line slot contents are queued by
// the stimulus process and checked by an independent line monitor at the
// first and last pixel of each queued line.
module tb_oam_scheduler;
  import tank_pkg::*;

  localparam int N_OBJ    = 16;
  localparam int N_SLOT   = 4;
  localparam int SPR_H    = 8;
  localparam int H_ACTIVE = 40;
  localparam int H_TOTAL  = 64;
  localparam int V_ACTIVE = 24;
  localparam int V_TOTAL  = 30;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   x;
  logic [9:0]   y;
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         commit;
  logic [127:0] slot_data;
  logic         line_overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int startModel = 0;

  typedef struct {
    int           line;
    logic [127:0] slots;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];

  oam_scheduler #(
    .N_OBJ(N_OBJ), .N_SLOT(N_SLOT), .SPR_H(SPR_H),
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .x             (x),
    .y             (y),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .slot_data     (slot_data),
    .line_overflow (line_overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Raster generator, updated just after each rising edge.
  initial begin
    x = 10'd0;
    y = 10'd0;
    forever begin
      @(posedge clk);
      #1;
      if (int'(x) == H_TOTAL - 1) begin
        x = 10'd0;
        y = (int'(y) == V_TOTAL - 1) ? 10'd0 : y + 10'd1;
      end else begin
        x = x + 10'd1;
      end
    end
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input logic en,
                                     input logic [9:0] px, input logic [9:0] py,
                                     input logic [2:0] r, input logic [2:0] c);
    return {1'b0, t, en, px, py, 2'b00, r, c};
  endfunction

  function automatic logic [31:0] ovfEntry(input int i);
    return mk(2'(i % 4), 1'b1, 10'(i * 7), 10'd2, 3'(i), 3'(i));
  endfunction

  // Slots for the five-object overflow setup when the scan begins at s.
  function automatic logic [127:0] ovfSlots(input int s);
    logic [127:0] res;
    int n;
    int id;
    res = '0;
    n = 0;
    for (int i = 0; i < N_OBJ; i++) begin
      id = (s + i) % N_OBJ;
      if (id < 5 && n < N_SLOT) begin
        res[n*32 +: 32] = ovfEntry(id);
        n++;
      end
    end
    return res;
  endfunction

  function automatic int scanStart();
`ifdef OAM_SCHED_PRIO_ROTATE_EN
    return startModel;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expectLine(input int line, input logic [127:0] slots, input logic ovf);
    exp_t e;
    e.line  = line;
    e.slots = slots;
    e.ovf   = ovf;
    sbq.push_back(e);
  endtask

  task automatic drainCheck(input string name);
    checkOutput(name, 128'(sbq.size()), 128'(0));
    sbq.delete();
  endtask

  task automatic waitRaster(input int yy, input int xx);
    int n;
    n = 0;
    @(negedge clk);
    while (!(int'(y) == yy && int'(x) == xx) && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_timeout actual=y%0d,x%0d required=y%0d,x%0d", y, x, yy, xx);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    wr_addr  = addr;
    wr_data  = data;
    wr_valid = 1'b1;
    while (!wr_ready && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic commitPulse();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Line monitor: compares slot outputs at the first and last pixel of each
  // queued line; tracks the per-frame scan start for the rotating build.
  always @(negedge clk) begin
    if (!rst_n) begin
      startModel = 0;
    end else if (x == 10'd0 && int'(y) == V_ACTIVE) begin
      startModel = (startModel + 1) % N_OBJ;
    end
    if (rst_n && sbq.size() > 0 && int'(y) == sbq[0].line) begin
      if (x == 10'd0) begin
        checkOutput($sformatf("line%0d_slots_first", y), slot_data, sbq[0].slots);
        checkOutput($sformatf("line%0d_ovf_first", y), 128'(line_overflow), 128'(sbq[0].ovf));
      end else if (int'(x) == H_TOTAL - 1) begin
        checkOutput($sformatf("line%0d_slots_last", y), slot_data, sbq[0].slots);
        checkOutput($sformatf("line%0d_ovf_last", y), 128'(line_overflow), 128'(sbq[0].ovf));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [31:0]  e3a;
    logic [31:0]  e3b;
    logic [31:0]  e7;
    logic [31:0]  eb;
    logic [31:0]  ew;
    logic [127:0] ov;
    int stall;

    e3a = mk(2'd1, 1'b1, 10'd100, 10'd10, 3'd2, 3'd5);
    e3b = mk(2'd0, 1'b1, 10'd200, 10'd5, 3'd1, 3'd1);
    e7  = mk(2'd3, 1'b1, 10'd300, 10'd15, 3'd7, 3'd7);
    eb  = mk(2'd0, 1'b1, 10'd5, 10'd20, 3'd0, 3'd0);
    ew  = mk(2'd0, 1'b1, 10'd6, 10'd1020, 3'd1, 3'd1);

    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    commit   = 1'b0;

    // Reset values, then write port comes up one edge after release.
    repeat (5) @(negedge clk);
    checkOutput("rst_slots", slot_data, '0);
    checkOutput("rst_ovf", 128'(line_overflow), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_wr_ready", 128'(wr_ready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("wr_ready_before_edge", 128'(wr_ready), 128'(0));
    @(negedge clk);
    checkOutput("wr_ready_after_edge", 128'(wr_ready), 128'(1));

    // Basic hit: entry 3 at pos_y 10 covers lines 10..17.
    applyStimulus(4'd3, e3a);
    commitPulse();
    waitRaster(V_ACTIVE + 1, 0);
    // Uncommitted rewrite of entry 3 must not show next frame.
    applyStimulus(4'd3, e3b);
    expectLine(5, '0, 1'b0);
    expectLine(9, '0, 1'b0);
    expectLine(10, {96'b0, e3a}, 1'b0);
    expectLine(13, {96'b0, e3a}, 1'b0);
    expectLine(17, {96'b0, e3a}, 1'b0);
    expectLine(18, '0, 1'b0);
    // Mid-frame commit only lands at the next vblank.
    waitRaster(12, 5);
    commitPulse();
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_basic");
    expectLine(4, '0, 1'b0);
    expectLine(5, {96'b0, e3b}, 1'b0);
    expectLine(12, {96'b0, e3b}, 1'b0);
    expectLine(13, '0, 1'b0);
    expectLine(17, '0, 1'b0);

    // Overflow: five objects on lines 2..9.
    for (int i = 0; i < 5; i++) applyStimulus(4'(i), ovfEntry(i));
    commitPulse();
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_commit");
    for (int f = 0; f < 5; f++) begin
      ov = ovfSlots(scanStart());
      expectLine(1, '0, 1'b0);
      expectLine(2, ov, 1'b1);
      expectLine(5, ov, 1'b1);
      expectLine(9, ov, 1'b1);
      expectLine(10, '0, 1'b0);
      waitRaster(V_ACTIVE + 1, 0);
      drainCheck($sformatf("sb_drain_ovf%0d", f));
    end

    // Write stall during the copy; the stalled write misses this copy.
    commitPulse();
    waitRaster(V_ACTIVE, 1);
    checkOutput("busy_copy", 128'(busy), 128'(1));
    wr_addr  = 4'd7;
    wr_data  = e7;
    wr_valid = 1'b1;
    stall = 0;
    while (!wr_ready && stall < 100) begin
      stall++;
      @(negedge clk);
    end
    checkOutput("stall_cycles", 128'(stall), 128'(N_OBJ));
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    expectLine(2, ovfSlots(scanStart()), 1'b1);
    expectLine(15, '0, 1'b0);
    waitRaster(V_ACTIVE + 1, 0);
    commitPulse();
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_stall");
    expectLine(2, ovfSlots(scanStart()), 1'b1);
    expectLine(15, {96'b0, e7}, 1'b0);
    expectLine(22, {96'b0, e7}, 1'b0);
    expectLine(23, '0, 1'b0);

    // Bottom edge: object at 20 stops at the last active line; an object
    // near 1023 must not wrap onto the top lines.
    applyStimulus(4'd0, eb);
    for (int i = 1; i < 5; i++) applyStimulus(4'(i), 32'h0);
    applyStimulus(4'd7, ew);
    commitPulse();
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_e7");
    expectLine(0, '0, 1'b0);
    expectLine(3, '0, 1'b0);
    expectLine(19, '0, 1'b0);
    expectLine(20, {96'b0, eb}, 1'b0);
    expectLine(23, {96'b0, eb}, 1'b0);
    expectLine(24, '0, 1'b0);
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_bottom");

    // Reset in the middle of an evaluation clears everything at once.
    waitRaster(21, H_ACTIVE + 3);
    checkOutput("busy_eval", 128'(busy), 128'(1));
    checkOutput("pre_reset_slots", slot_data, {96'b0, eb});
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_slots", slot_data, '0);
    checkOutput("mid_rst_busy", 128'(busy), 128'(0));
    checkOutput("mid_rst_wr_ready", 128'(wr_ready), 128'(0));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expectLine(22, '0, 1'b0);
    expectLine(23, '0, 1'b0);
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_reset");
    expectLine(20, '0, 1'b0);
    waitRaster(V_ACTIVE + 1, 0);
    drainCheck("sb_drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
